// File: rtl/param_seq_mult.sv
// Sequential shift-add multiplier with signed/unsigned operands.
// One ITER edge per significant multiplier bit, then a FIX edge applies the sign.
module param_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               SYS_CLOCK,
  input  logic               FSM_ARESET,
  input  logic               GO,
  input  logic               SIGNED_MODE,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] F_REG,
  output logic               BUSY,
  output logic               DONE
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    f_reg_q, f_reg_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] mplier_shr;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is exact as unsigned.
  assign a_mag      = (SIGNED_MODE && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign b_mag      = (SIGNED_MODE && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
  assign mplier_shr = mplier_q >> 1;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    f_reg_d  = f_reg_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (GO) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          neg_d    = SIGNED_MODE & (A[WIDTH-1] ^ B[WIDTH-1]);
          cnt_d    = '0;
          state_d  = (b_mag == '0) ? FIX : ITER;
        end
      end
      ITER: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CW'(1);
        // Stop as soon as no multiplier bits remain; the count guard bounds it at WIDTH edges.
        if ((mplier_shr == '0) || (cnt_q == CW'(WIDTH - 1))) begin
          state_d = FIX;
        end
      end
      FIX: begin
        f_reg_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SYS_CLOCK) begin
    if (FSM_ARESET) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      f_reg_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      f_reg_q  <= f_reg_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  assign F_REG = f_reg_q;
  assign DONE  = done_q;
  assign BUSY  = (state_q != IDLE);

endmodule
